dibit_serializer: RTL and testbench

//  Upstream feeder for the 2-bit registered stage: accepts a GROUPSIZE-bit word over a

---
 rtl/dibit_pkg.sv | 23 ++
 rtl/mod_n_counter.sv | 40 ++++
 rtl/dibit_serializer.sv | 85 ++++++++
 tb/tb_dibit_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dibit_pkg.sv
// ---------------------------------------------------------------------------
// Module : dibit_pkg
// Brief  : Shared types and helpers for the dibit serializer/deserializer pair.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dibit_pkg;

    localparam int DIBIT_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int ndib(input int groupsize);
        return groupsize / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------------------
// Module : mod_n_counter
// Brief  : Modulo-N up counter with clear priority and a terminal-count pulse.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_n_counter #(
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] c_TOP = CW'(N - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == c_TOP) ? '0 : r_count + CW'(1);
        end
    end

    assign count = r_count;
    // Pulses on the increment that rolls the count back to zero.
    assign wrap  = inc & (r_count == c_TOP);

endmodule

`default_nettype wire

// File: rtl/dibit_serializer.sv
// ---------------------------------------------------------------------------
// Module : dibit_serializer
// Brief  : Word-to-dibit serializer with valid/ready on both sides.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dibit_serializer
    import dibit_pkg::*;
#(
    parameter int GROUPSIZE = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GROUPSIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DIBIT_W-1:0]   dibit_out,
    output logic                 dibit_valid,
    output logic                 dibit_last,
    input  logic                 dibit_ready,
    output logic                 busy
);

    localparam int NDIB = ndib(GROUPSIZE);
    localparam int CW   = (NDIB > 1) ? $clog2(NDIB) : 1;

    generate
        if ((GROUPSIZE % 2) != 0 || GROUPSIZE < 4) begin : g_param_check
            $error("dibit_serializer: GROUPSIZE must be even and >= 4");
        end
    endgenerate

    ser_state_t          r_state;
    logic [GROUPSIZE-1:0] r_shreg;
    logic [CW-1:0]       w_count;
    logic                w_wrap;
    logic                w_valid;
    logic                w_beat;
    logic                w_accept;
    logic [DIBIT_W-1:0]  w_sym;

    assign w_valid  = (r_state == SEND);
    assign w_beat   = w_valid & dibit_ready;
    assign w_sym    = MSB_FIRST ? r_shreg[GROUPSIZE-1 -: DIBIT_W] : r_shreg[DIBIT_W-1:0];

    assign dibit_valid = w_valid;
    assign dibit_out   = w_valid ? w_sym : '0;
    assign dibit_last  = w_valid & (w_count == CW'(NDIB - 1));
    assign busy        = w_valid;
    // dibit_ready reaches in_ready combinationally so the next word lands with no bubble.
    assign in_ready    = (r_state == IDLE) | (w_valid & dibit_last & dibit_ready);
    assign w_accept    = in_valid & in_ready;

    mod_n_counter #(
        .N  (NDIB),
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_beat),
        .clr   (w_accept),
        .count (w_count),
        .wrap  (w_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
        end else if (w_accept) begin
            r_state <= SEND;
            r_shreg <= in_data;
        end else if (w_beat) begin
            r_shreg <= MSB_FIRST ? (r_shreg << DIBIT_W) : (r_shreg >> DIBIT_W);
            if (w_wrap) begin
                r_state <= IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dibit_serializer.sv
// ---------------------------------------------------------------------------
// Module : tb_dibit_serializer
// Brief  : Directed + random bench for dibit_serializer, both bit orders in parallel.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dibit_serializer;

    localparam int GS = 8;
    localparam int ND = GS / 2;

    typedef struct {
        logic [1:0] sym;
        logic       last;
    } sym_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [GS-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          dibit_ready = 1'b1;

    logic       rdy_m, val_m, last_m, busy_m;
    logic [1:0] out_m;
    logic       rdy_l, val_l, last_l, busy_l;
    logic [1:0] out_l;

    int checks = 0;
    int errors = 0;

    sym_t qm[$];
    sym_t ql[$];
    bit   accepted = 1'b0;

    always #5 clk = ~clk;

    dibit_serializer #(.GROUPSIZE(GS), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .dibit_out(out_m), .dibit_valid(val_m),
        .dibit_last(last_m), .dibit_ready(dibit_ready), .busy(busy_m)
    );

    dibit_serializer #(.GROUPSIZE(GS), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .dibit_out(out_l), .dibit_valid(val_l),
        .dibit_last(last_l), .dibit_ready(dibit_ready), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Symbol k of word w in transmit order.
    function automatic logic [1:0] sym_of(input logic [GS-1:0] w, input int k, input bit msb);
        int sh;
        sh = msb ? (GS - 2 - 2 * k) : (2 * k);
        return w[sh +: 2];
    endfunction

    function automatic logic exp_ready(input int qsize, input logic qlast);
        return (qsize == 0) || (qlast && dibit_ready);
    endfunction

    task automatic check_all(input bit chk_ready);
        sym_t hm, hl;
        hm = '{sym: 2'b00, last: 1'b0};
        hl = '{sym: 2'b00, last: 1'b0};
        if (qm.size() > 0) hm = qm[0];
        if (ql.size() > 0) hl = ql[0];
        chk("msb_valid", 8'(val_m),  8'(qm.size() > 0));
        chk("msb_out",   8'(out_m),  8'(hm.sym));
        chk("msb_last",  8'(last_m), 8'(hm.last));
        chk("msb_busy",  8'(busy_m), 8'(qm.size() > 0));
        chk("lsb_valid", 8'(val_l),  8'(ql.size() > 0));
        chk("lsb_out",   8'(out_l),  8'(hl.sym));
        chk("lsb_last",  8'(last_l), 8'(hl.last));
        if (chk_ready) begin
            chk("msb_in_ready", 8'(rdy_m), 8'(exp_ready(qm.size(), hm.last)));
            chk("lsb_in_ready", 8'(rdy_l), 8'(exp_ready(ql.size(), hl.last)));
        end
    endtask

    // Advance the reference by one clock using the inputs present at the edge.
    task automatic model_update();
        bit   beat, acc;
        logic hl;
        hl       = (qm.size() > 0) ? qm[0].last : 1'b0;
        beat     = (qm.size() > 0) && dibit_ready;
        acc      = in_valid && exp_ready(qm.size(), hl);
        accepted = acc;
        if (beat) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (acc) begin
            for (int k = 0; k < ND; k++) begin
                qm.push_back('{sym: sym_of(in_data, k, 1'b1), last: (k == ND - 1)});
                ql.push_back('{sym: sym_of(in_data, k, 1'b0), last: (k == ND - 1)});
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all(reset);
        @(posedge clk);
        if (reset) model_update();
        #1;
    endtask

    initial begin
        // Reset held for three cycles.
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("idle_in_ready", 8'(rdy_m), 8'd1);
        chk("idle_out", 8'(out_m), 8'd0);

        // Single word 8'hB4.
        in_valid = 1'b1; in_data = 8'hB4;
        step();
        in_valid = 1'b0;
        repeat (ND + 2) step();

        // Back-to-back FF then 00.
        in_valid = 1'b1; in_data = 8'hFF;
        step();
        in_data = 8'h00;
        while (!accepted) step();
        step();
        while (!accepted) step();
        in_valid = 1'b0;
        repeat (ND + 1) step();

        // Backpressure on the second symbol of 8'hB4.
        in_valid = 1'b1; in_data = 8'hB4;
        step();
        in_valid = 1'b0;
        step();
        dibit_ready = 1'b0;
        repeat (3) step();
        dibit_ready = 1'b1;
        repeat (ND) step();

        // Reset mid-word after two symbols of 8'hB4.
        in_valid = 1'b1; in_data = 8'hB4;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        #2 reset = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        chk("rst_mid_valid_m", 8'(val_m), 8'd0);
        chk("rst_mid_out_m",   8'(out_m), 8'd0);
        chk("rst_mid_valid_l", 8'(val_l), 8'd0);
        chk("rst_mid_out_l",   8'(out_l), 8'd0);
        step();
        reset = 1'b1;
        step();
        in_valid = 1'b1; in_data = 8'h1B;
        step();
        in_valid = 1'b0;
        repeat (ND + 1) step();

        // Random traffic; upstream holds a word until it is taken.
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = GS'($urandom);
            end
            dibit_ready = ($urandom_range(3) != 0);
            step();
        end
        in_valid = 1'b0;
        dibit_ready = 1'b1;
        repeat (2 * ND) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
